// File: rtl/trace_debugger_top.sv
// E-trace style instruction trace encoder: compresses the retire stream into branch-map,
// START, TRAP and ADDR packets. Define TRDB_TRAP_TVAL_EN to carry tval in TRAP packets.
module trace_debugger_top #(
  parameter int XLEN        = 32,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2,
  parameter int INST_LEN    = 32,
  parameter int PTYPE_LEN   = 4,
  parameter int P_LEN       = 5,
  parameter int PAYLOAD_LEN = 192
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   inst_valid_i,
  input  logic                   iretired_i,
  input  logic                   exception_i,
  input  logic                   interrupt_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-3:0]        tvec_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic [PRIV_LEN-1:0]    priv_lvl_i,
  input  logic [INST_LEN-1:0]    inst_data_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        epc_i,
  output logic [PTYPE_LEN-1:0]   packet_type_o,
  output logic [P_LEN-1:0]       packet_length_o,
  output logic [PAYLOAD_LEN-1:0] packet_payload_o
);

  typedef enum logic [PTYPE_LEN-1:0] {
    PKT_NONE = 0, PKT_BRANCH_FULL = 1, PKT_ADDR = 2, PKT_START = 3, PKT_TRAP = 4
  } pkt_e;

  typedef enum logic [1:0] {KIND_OTHER, KIND_BRANCH, KIND_JALR} kind_e;

  localparam int MAP_W      = 31;
  localparam int HDR_BITS   = 5 + MAP_W;
  localparam int ADDR_BITS  = HDR_BITS + XLEN;
  localparam int START_BITS = HDR_BITS + PRIV_LEN + XLEN;
`ifdef TRDB_TRAP_TVAL_EN
  localparam int TVAL_BITS  = XLEN;
`else
  localparam int TVAL_BITS  = 0;
`endif
  localparam int T_INTR     = HDR_BITS + PRIV_LEN;
  localparam int T_CAUSE    = T_INTR + 1;
  localparam int T_EPC      = T_CAUSE + CAUSE_LEN;
  localparam int T_TVAL     = T_EPC + XLEN;
  localparam int T_TVEC     = T_TVAL + TVAL_BITS;
  localparam int TRAP_BITS  = T_TVEC + XLEN - 2;

  function automatic logic [P_LEN-1:0] bytes_of(input int bits);
    return P_LEN'((bits + 7) / 8);
  endfunction

  logic retire, trap, resolve;
  assign retire  = inst_valid_i && iretired_i;
  assign trap    = inst_valid_i && (exception_i || interrupt_i);
  assign resolve = retire || trap;

  // State describing the last retired instruction and the branch map
  logic [XLEN-1:0]     prev_pc_q;
  logic                prev_len4_q;
  kind_e               prev_kind_q;
  logic [4:0]          count_q;
  logic [MAP_W-1:0]    map_q;
  logic                first_q;
  logic                trap_seen_q;
  logic [PRIV_LEN-1:0] last_priv_q;

  pkt_e                type_q;
  logic [P_LEN-1:0]    len_q;
  logic [PAYLOAD_LEN-1:0] payload_q;

  kind_e cur_kind;
  logic  cur_len4;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_len4 = (inst_data_i[1:0] == 2'b11);
    cur_kind = KIND_OTHER;
    if (cur_len4) begin
      if (inst_data_i[6:0] == 7'b1100011)      cur_kind = KIND_BRANCH;
      else if (inst_data_i[6:0] == 7'b1100111) cur_kind = KIND_JALR;
    end else if (inst_data_i[1:0] == 2'b01 && inst_data_i[15:14] == 2'b11) begin
      cur_kind = KIND_BRANCH;                  // c.beqz / c.bnez
    end else if (inst_data_i[1:0] == 2'b10 && inst_data_i[15:13] == 3'b100 &&
                 inst_data_i[11:7] != 5'd0 && inst_data_i[6:2] == 5'd0) begin
      cur_kind = KIND_JALR;                    // c.jr / c.jalr
    end
  end

  logic [XLEN-1:0]  target, seq_pc;
  logic [4:0]       count_nx;
  logic [MAP_W-1:0] map_nx;

  assign target = trap ? epc_i : pc_i;
  assign seq_pc = prev_pc_q + (prev_len4_q ? XLEN'(4) : XLEN'(2));

  always_comb begin
    map_nx   = map_q;
    count_nx = count_q;
    if (resolve && prev_kind_q == KIND_BRANCH) begin
      map_nx[count_q] = (target == seq_pc);    // 1 = not taken
      count_nx        = count_q + 5'd1;
    end
  end

  logic req_start, req_addr, req_full;
  assign req_start = retire && (first_q || (priv_lvl_i != last_priv_q && !trap_seen_q));
  assign req_addr  = retire && !trap && prev_kind_q == KIND_JALR;
  assign req_full  = (count_nx == 5'd31);

  pkt_e                   type_nx;
  logic [P_LEN-1:0]       len_nx;
  logic [PAYLOAD_LEN-1:0] payload_nx;

  always_comb begin
    type_nx    = PKT_NONE;
    len_nx     = '0;
    payload_nx = '0;
    if (trap) begin
      type_nx = PKT_TRAP;
      len_nx  = bytes_of(TRAP_BITS);
      payload_nx[HDR_BITS +: PRIV_LEN] = priv_lvl_i;
      payload_nx[T_INTR]               = interrupt_i;
      payload_nx[T_CAUSE +: CAUSE_LEN] = cause_i;
      payload_nx[T_EPC +: XLEN]        = epc_i;
`ifdef TRDB_TRAP_TVAL_EN
      payload_nx[T_TVAL +: XLEN]       = tval_i;
`endif
      payload_nx[T_TVEC +: XLEN-2]     = tvec_i;
    end else if (req_start) begin
      type_nx = PKT_START;
      len_nx  = bytes_of(START_BITS);
      payload_nx[HDR_BITS +: PRIV_LEN]        = priv_lvl_i;
      payload_nx[HDR_BITS + PRIV_LEN +: XLEN] = pc_i;
    end else if (req_addr) begin
      type_nx = PKT_ADDR;
      len_nx  = bytes_of(ADDR_BITS);
      payload_nx[HDR_BITS +: XLEN] = pc_i;
    end else if (req_full) begin
      type_nx = PKT_BRANCH_FULL;
      len_nx  = bytes_of(HDR_BITS);
    end
    // Any packet carries the map, including outcomes resolved this cycle
    if (type_nx != PKT_NONE) begin
      payload_nx[4:0]          = count_nx;
      payload_nx[5 +: MAP_W]   = map_nx;
    end
  end

  // NOTE: the output registers are reset asynchronously so a reset clears the packet at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_q      <= PKT_NONE;
      len_q       <= '0;
      payload_q   <= '0;
      prev_pc_q   <= '0;
      prev_len4_q <= 1'b1;
      prev_kind_q <= KIND_OTHER;
      count_q     <= '0;
      map_q       <= '0;
      first_q     <= 1'b1;
      trap_seen_q <= 1'b0;
      last_priv_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      type_q    <= type_nx;
      len_q     <= len_nx;
      payload_q <= payload_nx;
      if (type_nx != PKT_NONE) begin
        count_q <= '0;
        map_q   <= '0;
      end else begin
        count_q <= count_nx;
        map_q   <= map_nx;
      end
      if (trap) begin
        prev_kind_q <= KIND_OTHER;
        trap_seen_q <= 1'b1;
      end else if (retire) begin
        prev_pc_q   <= pc_i;
        prev_len4_q <= cur_len4;
        prev_kind_q <= cur_kind;
        first_q     <= 1'b0;
        trap_seen_q <= 1'b0;
        last_priv_q <= priv_lvl_i;
      end
    end
  end

  assign packet_type_o    = type_q;
  assign packet_length_o  = len_q;
  assign packet_payload_o = payload_q;

  logic unused_inputs;
`ifdef TRDB_TRAP_TVAL_EN
  assign unused_inputs = ^{test_mode_i, inst_data_i[INST_LEN-1:16]};
`else
  assign unused_inputs = ^{test_mode_i, inst_data_i[INST_LEN-1:16], tval_i};
`endif

endmodule

// File: tb/tb_trace_debugger_top.sv
// Self-checking bench for trace_debugger_top: directed scenarios plus random retire/trap
// traffic checked against a queue-based packet model.
module tb_trace_debugger_top;

  localparam int K_OTHER = 0, K_BRANCH = 1, K_JALR = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         test_mode_i;
  logic         inst_valid_i, iretired_i, exception_i, interrupt_i;
  logic [4:0]   cause_i;
  logic [29:0]  tvec_i;
  logic [31:0]  tval_i;
  logic [1:0]   priv_lvl_i;
  logic [31:0]  inst_data_i, pc_i, epc_i;
  logic [3:0]   packet_type_o;
  logic [4:0]   packet_length_o;
  logic [191:0] packet_payload_o;

  trace_debugger_top dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
    .inst_valid_i(inst_valid_i), .iretired_i(iretired_i),
    .exception_i(exception_i), .interrupt_i(interrupt_i),
    .cause_i(cause_i), .tvec_i(tvec_i), .tval_i(tval_i), .priv_lvl_i(priv_lvl_i),
    .inst_data_i(inst_data_i), .pc_i(pc_i), .epc_i(epc_i),
    .packet_type_o(packet_type_o), .packet_length_o(packet_length_o),
    .packet_payload_o(packet_payload_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: last retired instruction and resolved branch outcomes, oldest first
  bit          m_first, m_trap_seen;
  bit [1:0]    m_last_priv;
  bit [31:0]   m_prev_pc, m_prev_len;
  int          m_prev_kind;
  bit          m_map[$];
  int          s_kind;
  bit          s_len4;
  bit [3:0]    exp_type;
  bit [4:0]    exp_len;
  bit [191:0]  exp_payload;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pkt(input string tag);
    check({tag, " type"}, packet_type_o, exp_type);
    check({tag, " length"}, packet_length_o, exp_len);
    check({tag, " payload"}, packet_payload_o, exp_payload);
  endtask

  function automatic bit [31:0] encode(input int kind, input bit len4);
    bit [31:0] w;
    int        pick;
    pick = int'($urandom_range(0, 3));
    w    = 32'h0;
    if (len4) begin
      case (kind)
        K_BRANCH: w = (pick == 0) ? 32'h0000_0063 : (pick == 1) ? 32'h0000_1063 : 32'h00B5_0463;
        K_JALR:   w = (pick < 2) ? 32'h0000_8067 : 32'h0000_80E7;
        default:  w = (pick == 0) ? 32'h0000_0013 : (pick == 1) ? 32'h0000_006F : 32'h0000_0033;
      endcase
    end else begin
      w[31:16] = 16'($urandom);
      case (kind)
        K_BRANCH: w[15:0] = (pick < 2) ? 16'hC001 : 16'hE001;
        K_JALR:   w[15:0] = (pick < 2) ? 16'h8082 : 16'h9082;
        default:  w[15:0] = (pick == 0) ? 16'h0001 : (pick == 1) ? 16'hA001 :
                            (pick == 2) ? 16'h9002 : 16'h4501;
      endcase
    end
    return w;
  endfunction

  task automatic model_reset();
    m_first     = 1'b1;
    m_trap_seen = 1'b0;
    m_last_priv = 2'd0;
    m_prev_pc   = 32'h0;
    m_prev_len  = 32'd4;
    m_prev_kind = K_OTHER;
    m_map.delete();
  endtask

  task automatic model_step();
    bit        is_ret, is_trap, addr_req, start_req;
    bit [31:0] target;
    bit [191:0] p;
    exp_type    = 4'd0;
    exp_len     = 5'd0;
    exp_payload = '0;
    if (!inst_valid_i) return;
    is_ret   = iretired_i;
    is_trap  = exception_i || interrupt_i;
    addr_req = 1'b0;
    if (is_ret || is_trap) begin
      target = is_trap ? epc_i : pc_i;
      if (m_prev_kind == K_BRANCH) m_map.push_back(target == m_prev_pc + m_prev_len);
      addr_req = !is_trap && m_prev_kind == K_JALR;
    end
    start_req = is_ret && (m_first || (priv_lvl_i != m_last_priv && !m_trap_seen));
    p = '0;
    p[4:0] = 5'(m_map.size());
    foreach (m_map[i]) p[5 + i] = m_map[i];
    if (is_trap) begin
      p[37:36] = priv_lvl_i;
      p[38]    = interrupt_i;
      p[43:39] = cause_i;
      p[75:44] = epc_i;
`ifdef TRDB_TRAP_TVAL_EN
      p[107:76]  = tval_i;
      p[137:108] = tvec_i;
      exp_len    = 5'd18;
`else
      p[105:76]  = tvec_i;
      exp_len    = 5'd14;
`endif
      exp_type = 4'd4;
    end else if (start_req) begin
      p[37:36] = priv_lvl_i;
      p[69:38] = pc_i;
      exp_type = 4'd3;
      exp_len  = 5'd9;
    end else if (addr_req) begin
      p[67:36] = pc_i;
      exp_type = 4'd2;
      exp_len  = 5'd9;
    end else if (m_map.size() == 31) begin
      exp_type = 4'd1;
      exp_len  = 5'd5;
    end
    if (exp_type != 4'd0) begin
      exp_payload = p;
      m_map.delete();
    end
    if (is_trap) begin
      m_prev_kind = K_OTHER;
      m_trap_seen = 1'b1;
    end else if (is_ret) begin
      m_prev_pc   = pc_i;
      m_prev_len  = s_len4 ? 32'd4 : 32'd2;
      m_prev_kind = s_kind;
      m_first     = 1'b0;
      m_trap_seen = 1'b0;
      m_last_priv = priv_lvl_i;
    end
  endtask

  task automatic cyc(input string tag, input bit v, input bit r, input bit ex, input bit irq,
                     input bit [1:0] pr, input bit [31:0] pc, input bit [31:0] epc,
                     input int kind, input bit len4);
    @(negedge clk_i);
    inst_valid_i = v;
    iretired_i   = r;
    exception_i  = ex;
    interrupt_i  = irq;
    priv_lvl_i   = pr;
    pc_i         = pc;
    epc_i        = epc;
    s_kind       = kind;
    s_len4       = len4;
    inst_data_i  = encode(kind, len4);
    test_mode_i  = 1'($urandom);
    model_step();
    @(posedge clk_i);
    #1;
    check_pkt(tag);
  endtask

  task automatic retire(input string tag, input bit [31:0] pc, input bit [1:0] pr,
                        input int kind, input bit len4);
    cause_i = 5'($urandom);
    tval_i  = $urandom;
    tvec_i  = 30'($urandom);
    cyc(tag, 1'b1, 1'b1, 1'b0, 1'b0, pr, pc, $urandom, kind, len4);
  endtask

  task automatic trap_ev(input string tag, input bit irq, input bit [4:0] cause,
                         input bit [31:0] epc, input bit [31:0] tval, input bit [29:0] tvec,
                         input bit [1:0] pr);
    cause_i = cause;
    tval_i  = tval;
    tvec_i  = tvec;
    cyc(tag, 1'b1, 1'b0, !irq, irq, pr, $urandom, epc, K_OTHER, 1'b1);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
        int'($urandom_range(0, 2)), 1'($urandom));
  endtask

  initial begin
    bit [1:0]  cur_priv;
    bit [31:0] rpc;
    rst_ni = 1'b0;
    test_mode_i = 1'b0; inst_valid_i = 1'b0; iretired_i = 1'b0;
    exception_i = 1'b0; interrupt_i = 1'b0; cause_i = '0; tvec_i = '0; tval_i = '0;
    priv_lvl_i = '0; inst_data_i = '0; pc_i = '0; epc_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset type", packet_type_o, 4'd0);
    check("reset length", packet_length_o, 5'd0);
    check("reset payload", packet_payload_o, 192'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // First retire after reset emits START
    retire("first start", 32'h8000_0000, 2'd3, K_OTHER, 1'b1);
    check("first start type", packet_type_o, 4'd3);
    check("first start len", packet_length_o, 5'd9);
    check("first start pc", packet_payload_o[69:38], 32'h8000_0000);
    check("first start priv", packet_payload_o[37:36], 2'd3);
    check("first start count", packet_payload_o[4:0], 5'd0);
    idle("idle after start");

    // 31 not-taken branches fill the map
    for (int i = 0; i < 31; i++) retire("beq run", 32'h1000 + 32'(4 * i), 2'd3, K_BRANCH, 1'b1);
    retire("full", 32'h1000 + 32'd124, 2'd3, K_OTHER, 1'b1);
    check("full type", packet_type_o, 4'd1);
    check("full len", packet_length_o, 5'd5);
    check("full count", packet_payload_o[4:0], 5'd31);
    check("full map", packet_payload_o[35:5], 31'h7FFF_FFFF);
    retire("after full", 32'h3000, 2'd1, K_OTHER, 1'b1);
    check("after full count", packet_payload_o[4:0], 5'd0);
    check("after full map", packet_payload_o[35:5], 31'd0);

    // Uninferable jump
    retire("jalr", 32'h100, 2'd1, K_JALR, 1'b1);
    retire("jalr target", 32'h2000, 2'd1, K_OTHER, 1'b1);
    check("addr type", packet_type_o, 4'd2);
    check("addr len", packet_length_o, 5'd9);
    check("addr value", packet_payload_o[67:36], 32'h2000);

    // Exception, then handler at a different privilege without START
    retire("pre trap", 32'h104, 2'd0, K_OTHER, 1'b1);
    trap_ev("trap", 1'b0, 5'd2, 32'h104, 32'hDEAD_BEEF, 30'h30, 2'd0);
    check("trap type", packet_type_o, 4'd4);
    check("trap cause", packet_payload_o[43:39], 5'd2);
    check("trap epc", packet_payload_o[75:44], 32'h104);
`ifdef TRDB_TRAP_TVAL_EN
    check("trap len", packet_length_o, 5'd18);
    check("trap tval", packet_payload_o[107:76], 32'hDEAD_BEEF);
    check("trap tvec", packet_payload_o[137:108], 30'h30);
`else
    check("trap len", packet_length_o, 5'd14);
    check("trap tvec", packet_payload_o[105:76], 30'h30);
`endif
    retire("handler first", 32'hC0, 2'd3, K_OTHER, 1'b1);
    check("handler no start", packet_type_o, 4'd0);
    retire("handler next", 32'hC4, 2'd3, K_OTHER, 1'b1);
    retire("back to user", 32'h108, 2'd0, K_OTHER, 1'b1);

    // Taken branch resolved by a privilege-change START
    retire("priv 3", 32'h0C, 2'd3, K_OTHER, 1'b1);
    retire("taken br", 32'h10, 2'd3, K_BRANCH, 1'b1);
    retire("start wins", 32'h40, 2'd0, K_OTHER, 1'b1);
    check("start wins type", packet_type_o, 4'd3);
    check("start wins count", packet_payload_o[4:0], 5'd1);
    check("start wins map0", packet_payload_o[5], 1'b0);

    // Compressed branch not taken, then random traffic
    retire("c.beqz", 32'h50, 2'd0, K_BRANCH, 1'b0);
    retire("c.beqz next", 32'h52, 2'd0, K_OTHER, 1'b1);
    cur_priv = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      int roll;
      roll = int'($urandom_range(0, 99));
      if (roll < 10) idle("rnd idle");
      else if (roll < 16)
        trap_ev("rnd trap", 1'($urandom), 5'($urandom), $urandom & ~32'h1, $urandom,
                30'($urandom), cur_priv);
      else begin
        if ($urandom_range(0, 49) == 0) cur_priv = 2'($urandom);
        rpc = ($urandom_range(0, 2) != 0) ? m_prev_pc + m_prev_len : ($urandom & ~32'h1);
        retire("rnd retire", rpc, cur_priv, int'($urandom_range(0, 2)), 1'($urandom));
      end
    end

    // Asynchronous reset while a TRAP is presented
    trap_ev("trap before reset", 1'b1, 5'd7, 32'h200, 32'h1234, 30'h44, cur_priv);
    check("trap before reset type", packet_type_o, 4'd4);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async reset type", packet_type_o, 4'd0);
    check("async reset length", packet_length_o, 5'd0);
    check("async reset payload", packet_payload_o, 192'd0);
    model_reset();
    inst_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    retire("start after reset", 32'h9000, cur_priv, K_OTHER, 1'b1);
    check("start after reset type", packet_type_o, 4'd3);
    idle("final idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
